ysyx_24100012_ifu: RTL and testbench
====================================

// Module: ysyx_24100012_ifu
// PURPOSE
//  Instruction fetch unit; sits directly upstream of the combinational instruction ROM.
//  - Holds the PC and drives the ROM address; captures the returned word.
//  - Buffers fetched words in a small FIFO and hands them to the decode stage
//    over a valid/ready handshake.
//  - Accepts redirects from execute and stops fetching after an ebreak.
// PARAMETERS
//  ADDR_WIDTH  32            PC / ROM address width
//  DATA_WIDTH  32            instruction width
//  RESET_PC    32'h80000000  PC loaded on reset
//  QDEPTH      2             fetch queue entries; power of two, >=2
//  EBREAK      32'h00100073  encoding that triggers halt
// PORTS
//  clk             in   1           clock, rising edge
//  rst             in   1           asynchronous reset, active-high
//  imem_addr       out  ADDR_WIDTH  ROM address (= pc, combinational)
//  imem_rdata      in   DATA_WIDTH  ROM data, combinational from imem_addr
//  inst_valid      out  1           queue head valid to decode
//  inst_ready      in   1           decode accepts head this cycle
//  inst            out  DATA_WIDTH  queue head instruction
//  inst_pc         out  ADDR_WIDTH  PC of queue head
//  redirect_valid  in   1           execute requests a new PC
//  redirect_pc     in   ADDR_WIDTH  target; bits [1:0] ignored (treated as 0)
//  halted          out  1           ebreak consumed by decode; sticky until rst
// BEHAVIOUR
//  Reset (async):
//   - pc=RESET_PC, queue empty, state=FETCH.
//   - inst_valid=0, halted=0; inst/inst_pc=0.
//  Definitions:
//   - pop  = inst_valid & inst_ready.
//   - push = state==FETCH & (count<QDEPTH | pop) & !redirect_valid.
//   - push writes {pc, imem_rdata} at tail; pc<=pc+4, wrapping modulo 2^ADDR_WIDTH.
//  Latency and throughput:
//   - A word pushed in cycle N is presented on inst/inst_pc in cycle N+1 at the earliest.
//   - Sustained rate is 1 instr/cycle when inst_ready=1.
//  Handshake:
//   - inst/inst_pc are held stable while inst_valid & !inst_ready.
//   - inst_valid = (count!=0) & state!=HALT.
//   - Push and pop in the same cycle when full is legal; count is unchanged.
//  States:
//   - FETCH: fetch each cycle push is true. If a pushed word == EBREAK -> DRAIN;
//     pc still advances past the ebreak.
//   - DRAIN: no push. When the ebreak entry is popped -> HALT.
//   - HALT: no push, no pop. halted=1, inst_valid=0. Leaves only via rst.
//  Redirect (highest priority; FETCH or DRAIN):
//   - Flush queue (count<=0), pc<={redirect_pc[ADDR_WIDTH-1:2],2'b00}, state<=FETCH.
//   - No push that cycle. A pop in the same cycle still completes.
//   - First redirected word is visible 2 cycles after the redirect cycle.
//  Redirect in HALT: ignored.
//  rst mid-operation: queue contents discarded immediately; outputs take reset values.
// STRUCTURE
//  Shared package:
//   - RESET_PC and EBREAK constants.
//   - state enum {FETCH, DRAIN, HALT}.
//   - fetch-entry struct {pc, inst}.
//  One sub-module: ysyx_24100012_fetch_fifo. Parametric sync FIFO:
//   - push/pop/flush inputs; full/empty/head outputs.
//   - wrapping rd/wr pointers with an extra wrap bit.
//  Top level: PC register, FSM, push/pop logic.
// TESTING
//  1) Straight-line: reset, ROM=addi at 0x80000000..0x80000014, inst_ready=1.
//     -> inst_pc=0x80000000 first valid at cycle 1, then +4 every cycle.
//  2) Backpressure: inst_ready=0 for 5 cycles.
//     -> count saturates at QDEPTH, pc stops at 0x80000008,
//        inst/inst_pc held at 0x80000000.
//     Release -> no instruction lost or duplicated.
//  3) Redirect: redirect_valid with redirect_pc=0x80000102.
//     -> queue flushed, inst_valid=0 next cycle,
//        inst_pc=0x80000100 two cycles after the redirect.
//  4) Ebreak: EBREAK at 0x80000018.
//     -> no fetch beyond 0x8000001c; halted=1 the cycle after the ebreak pops;
//        later redirect_valid ignored.
//  5) Redirect during DRAIN (branch ahead of ebreak) -> FETCH resumes, halted stays 0.
//  6) Wrap and reset: RESET_PC=32'hFFFFFFF8 -> pc sequence FFFFFFF8, FFFFFFFC, 00000000.
//     Assert rst mid-stream -> inst_valid=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/ysyx_24100012_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default constants,
// FSM state encoding and the fetch-queue entry layout.
package ysyx_24100012_ifu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [31:0] EBREAK_INST  = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } ifu_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/ysyx_24100012_fetch_fifo.sv
// Synchronous FIFO for fetched {pc, inst} entries. Pointers carry an extra
// wrap bit so full and empty are told apart without a separate counter.
module ysyx_24100012_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // When full, a push lands in the slot being popped this same cycle; the
   // head is read combinationally before the write takes effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: PC register driving a combinational ROM, a small
// fetch queue toward decode, execute redirects, and halt on ebreak.
module ysyx_24100012_ifu
   import ysyx_24100012_ifu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int                    QDEPTH     = 2,
   parameter logic [DATA_WIDTH-1:0] EBREAK     = EBREAK_INST
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   ifu_state_t              state;
   ifu_state_t              state_nxt;
   logic [ADDR_WIDTH-1:0]   pc;
   logic                    pop;
   logic                    push;
   logic                    redir;
   logic                    q_full;
   logic                    q_empty;
   logic [EW-1:0]           q_head;

   assign imem_addr  = pc;
   assign inst_valid = !q_empty && (state != HALT);
   assign pop        = inst_valid && inst_ready;
   assign redir      = redirect_valid && (state != HALT);
   assign push       = (state == FETCH) && (!q_full || pop) && !redirect_valid;
   assign halted     = (state == HALT);

   // Head is masked while nothing is presented so idle outputs read as zero.
   assign inst    = inst_valid ? q_head[DATA_WIDTH-1:0] : '0;
   assign inst_pc = inst_valid ? q_head[EW-1:DATA_WIDTH] : '0;

   ysyx_24100012_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redir),
      .wdata ({pc, imem_rdata}),
      .full  (q_full),
      .empty (q_empty),
      .head  (q_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redir) begin
         pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else if (push) begin
         pc <= pc + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   if (push && (imem_rdata == EBREAK)) state_nxt = DRAIN;
         DRAIN:   if (pop && (inst == EBREAK))        state_nxt = HALT;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
      // A redirect outranks both fetch and drain; redir is never set in HALT.
      if (redir) state_nxt = FETCH;
   end

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Directed bench for the fetch unit: a main instance at the default reset PC
// and a second instance whose reset PC sits just below the address wrap.
module tb_ysyx_24100012_ifu;

   localparam logic [31:0] EBR = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ebreak_on;

   logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
   logic        inst_valid, halted;
   logic [31:0] w_imem_addr, w_imem_rdata, w_inst, w_inst_pc;
   logic        w_inst_valid, w_halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // ROM: unique addi per address, optional ebreak at 0x80000018.
   function automatic logic [31:0] rom(input logic [31:0] a, input logic eb);
      if (eb && a == 32'h8000_0018) return EBR;
      return {a[13:2], 20'h00013};
   endfunction

   assign imem_rdata   = rom(imem_addr, ebreak_on);
   assign w_imem_rdata = rom(w_imem_addr, 1'b0);

   ysyx_24100012_ifu u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
   );

   ysyx_24100012_ifu #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .halted(w_halted)
   );

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   // Leaves the bench just after the edge that starts cycle 0.
   task automatic apply_reset();
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      nxt(); nxt();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ebreak_on = 1'b0;
      nxt();
      @(negedge clk);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
      total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst); end
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
      total++; if (imem_addr !== 32'h8000_0000) begin bad++; $display("FAIL rst_pc got=%h exp=80000000", imem_addr); end
      total++; if (w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rst_wrap_pc got=%h exp=fffffff8", w_imem_addr); end
      nxt();
   endtask

   task automatic test_straight();
      logic [31:0] e;
      apply_reset();
      inst_ready = 1'b1;
      @(negedge clk);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL st_c0_valid got=%b exp=0", inst_valid); end
      total++; if (imem_addr !== 32'h8000_0000) begin bad++; $display("FAIL st_c0_addr got=%h exp=80000000", imem_addr); end
      for (int k = 0; k < 6; k++) begin
         nxt();
         @(negedge clk);
         e = 32'h8000_0000 + 32'(4 * k);
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL st_valid k=%0d got=%b exp=1", k, inst_valid); end
         total++; if (inst_pc !== e) begin bad++; $display("FAIL st_pc k=%0d got=%h exp=%h", k, inst_pc, e); end
         total++; if (inst !== rom(e, 1'b0)) begin bad++; $display("FAIL st_inst k=%0d got=%h exp=%h", k, inst, rom(e, 1'b0)); end
         total++; if (imem_addr !== e + 32'd4) begin bad++; $display("FAIL st_addr k=%0d got=%h exp=%h", k, imem_addr, e + 32'd4); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] e;
      apply_reset();
      inst_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            total++; if (imem_addr !== 32'h8000_0008) begin bad++; $display("FAIL bp_addr c=%0d got=%h exp=80000008", c, imem_addr); end
            total++; if (inst_pc !== 32'h8000_0000) begin bad++; $display("FAIL bp_hold_pc c=%0d got=%h exp=80000000", c, inst_pc); end
            total++; if (inst !== rom(32'h8000_0000, 1'b0)) begin bad++; $display("FAIL bp_hold_inst c=%0d got=%h exp=%h", c, inst, rom(32'h8000_0000, 1'b0)); end
         end
         nxt();
      end
      inst_ready = 1'b1;
      e = 32'h8000_0000;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++; if (inst_valid !== 1'b1 || inst_pc !== e) begin bad++; $display("FAIL bp_release k=%0d got=%b/%h exp=1/%h", k, inst_valid, inst_pc, e); end
         e = e + 32'd4;
         nxt();
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      inst_ready = 1'b1;
      nxt(); nxt(); nxt();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
      nxt();
      redirect_valid = 1'b0;
      @(negedge clk);
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rd_flush got=%b exp=0", inst_valid); end
      total++; if (imem_addr !== 32'h8000_0100) begin bad++; $display("FAIL rd_addr got=%h exp=80000100", imem_addr); end
      nxt();
      @(negedge clk);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0100) begin bad++; $display("FAIL rd_first got=%b/%h exp=1/80000100", inst_valid, inst_pc); end
      total++; if (inst !== rom(32'h8000_0100, 1'b0)) begin bad++; $display("FAIL rd_inst got=%h exp=%h", inst, rom(32'h8000_0100, 1'b0)); end
      nxt();
      @(negedge clk);
      total++; if (inst_pc !== 32'h8000_0104) begin bad++; $display("FAIL rd_second got=%h exp=80000104", inst_pc); end
   endtask

   task automatic test_ebreak();
      apply_reset();
      ebreak_on = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 7; k++) nxt();
      @(negedge clk);
      total++; if (inst_valid !== 1'b1 || inst !== EBR) begin bad++; $display("FAIL eb_head got=%b/%h exp=1/%h", inst_valid, inst, EBR); end
      total++; if (inst_pc !== 32'h8000_0018) begin bad++; $display("FAIL eb_pc got=%h exp=80000018", inst_pc); end
      total++; if (imem_addr !== 32'h8000_001C) begin bad++; $display("FAIL eb_stop got=%h exp=8000001c", imem_addr); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL eb_early got=%b exp=0", halted); end
      nxt();
      @(negedge clk);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL eb_halted got=%b exp=1", halted); end
      total++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin bad++; $display("FAIL eb_quiet got=%b/%h exp=0/0", inst_valid, inst); end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      nxt();
      redirect_valid = 1'b0;
      nxt();
      @(negedge clk);
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL eb_sticky got=%b exp=1", halted); end
      total++; if (imem_addr !== 32'h8000_001C || inst_valid !== 1'b0) begin bad++; $display("FAIL eb_ignore got=%h/%b exp=8000001c/0", imem_addr, inst_valid); end
      ebreak_on = 1'b0;
   endtask

   task automatic test_drain_redirect();
      apply_reset();
      ebreak_on = 1'b1; inst_ready = 1'b1;
      for (int k = 0; k < 6; k++) nxt();
      inst_ready = 1'b0;
      nxt();
      @(negedge clk);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0014) begin bad++; $display("FAIL dr_head got=%b/%h exp=1/80000014", inst_valid, inst_pc); end
      total++; if (imem_addr !== 32'h8000_001C) begin bad++; $display("FAIL dr_stop got=%h exp=8000001c", imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
      nxt();
      redirect_valid = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      total++; if (inst_valid !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL dr_flush got=%b/%b exp=0/0", inst_valid, halted); end
      total++; if (imem_addr !== 32'h8000_0040) begin bad++; $display("FAIL dr_addr got=%h exp=80000040", imem_addr); end
      nxt();
      @(negedge clk);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0040) begin bad++; $display("FAIL dr_resume got=%b/%h exp=1/80000040", inst_valid, inst_pc); end
      nxt();
      @(negedge clk);
      total++; if (inst_pc !== 32'h8000_0044 || halted !== 1'b0) begin bad++; $display("FAIL dr_next got=%h/%b exp=80000044/0", inst_pc, halted); end
      ebreak_on = 1'b0;
   endtask

   task automatic test_wrap_reset();
      logic [31:0] e;
      apply_reset();
      inst_ready = 1'b1;
      @(negedge clk);
      total++; if (w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wr_c0 got=%h exp=fffffff8", w_imem_addr); end
      for (int k = 0; k < 4; k++) begin
         nxt();
         @(negedge clk);
         e = 32'hFFFF_FFF8 + 32'(4 * k);
         total++; if (w_inst_valid !== 1'b1 || w_inst_pc !== e) begin bad++; $display("FAIL wr_seq k=%0d got=%b/%h exp=1/%h", k, w_inst_valid, w_inst_pc, e); end
      end
      nxt();
      rst = 1'b1;
      #1;
      total++; if (w_inst_valid !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b/%b exp=0/0", w_inst_valid, inst_valid); end
      total++; if (w_imem_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL mr_wrap_pc got=%h exp=fffffff8", w_imem_addr); end
      total++; if (imem_addr !== 32'h8000_0000) begin bad++; $display("FAIL mr_pc got=%h exp=80000000", imem_addr); end
      total++; if (w_inst_pc !== 32'h0 || w_inst !== 32'h0) begin bad++; $display("FAIL mr_outs got=%h/%h exp=0/0", w_inst_pc, w_inst); end
      nxt();
      rst = 1'b0;
      nxt();
      @(negedge clk);
      total++; if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL mr_restart got=%b/%h exp=1/fffffff8", w_inst_valid, w_inst_pc); end
   endtask

   initial begin
      ebreak_on = 1'b0;
      test_reset();
      test_straight();
      test_backpressure();
      test_redirect();
      test_ebreak();
      test_drain_redirect();
      test_wrap_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
